data_lsu: RTL and testbench
===========================

# data_lsu

Load/store unit between the core's memory stage and the word-addressed data RAM. Accepts byte/halfword/word requests from the core and converts them into word-aligned RAM accesses with byte enables and replicated store data. Extracts and sign/zero-extends load data, and stalls the core until the access completes. It is the initiator in front of the data RAM, which has a combinational read and a clocked write.

## Interface
Parameters:
- `ADDR_W`, 32, core and memory address width
- `DATA_W`, 32, data width; fixed at 32, four byte lanes

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `core_req`  in  1  memory access request; held high by the core while `core_stall`=1
- `core_we`  in  1  1 = store, 0 = load
- `core_size`  in  3  funct3 encoding: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- `core_addr`  in  ADDR_W  byte address
- `core_wd`  in  DATA_W  store data, right-aligned
- `core_rd`  out  DATA_W  load result, extended; registered
- `core_stall`  out  1  core must hold its pipeline
- `misalign_err`  out  1  one-cycle pulse on misaligned or illegal request
- `mem_req`  out  1  RAM access strobe
- `mem_we`  out  1  RAM write enable; qualified by `mem_req`
- `mem_be`  out  4  byte enables
- `mem_addr`  out  ADDR_W  word-aligned address `{core_addr[ADDR_W-1:2],2'b00}`
- `mem_wd`  out  DATA_W  lane-replicated store data
- `mem_rd`  in  DATA_W  RAM read data
- `mem_ready`  in  1  RAM completes the access this cycle; tie to 1 for the single-cycle RAM

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - With `core_req`=1 and a legal, aligned request: latch `we`, `size`, `addr`, `wd`; assert `core_stall`; go to BUSY.
  - With an illegal request: `misalign_err`=1, `core_stall`=0, no memory access, stay IDLE. An illegal request is one of:
    - halfword with `addr[0]`=1;
    - word with `addr[1:0]`≠0;
    - stores with size ∉ {000,001,010};
    - loads with size ∉ {000,001,010,100,101}.
- BUSY: `mem_req`=1, with all `mem_*` driven from the latched request; `core_stall`=1.
  - `mem_ready`=0: stay in BUSY.
  - `mem_ready`=1: for a load, register the extracted `mem_rd` into `core_rd`; go to DONE.
- DONE: `core_stall`=0 for exactly one cycle; `core_rd` is valid; go to IDLE. A `core_req` present in DONE is ignored; the core advances past it this cycle.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `addr[1]` ? `1100` : `0011`
  - word: `1111`
- Store data: byte = `{4{wd[7:0]}}`, half = `{2{wd[15:0]}}`, word = `wd`.
- Load extract: select lane by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores leave `core_rd` unchanged.

## Timing
- Reset values: state IDLE, `core_rd`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `misalign_err`=0, latched request cleared.
- `core_stall` and `misalign_err` are combinational from state and the core inputs. All `mem_*` outputs are driven from registers and state only.
- Latency: 3 cycles from `core_req` to release with `mem_ready` tied to 1 (IDLE→BUSY→DONE); each added `mem_ready`=0 cycle adds one.
- `rst` asserted in BUSY or DONE: immediate return to reset values, with no partial write issued after reset. A write already strobed in BUSY may have landed.
- `misalign_err` in IDLE never enters BUSY.

## Structure
- `lsu_pkg`:
  - funct3 size localparams (`LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU`);
  - the `lsu_state_t` enum {IDLE, BUSY, DONE}.
- Sub-module `lsu_load_align`: combinational (`mem_rd`, `size`, `addr[1:0]`) → extended 32-bit result. It is shared with the verification model.

## Test plan
- SW addr 0x10, wd 0xDEADBEEF, ready=1 → BUSY cycle with `mem_be`=1111, `mem_addr`=0x10, `mem_wd`=0xDEADBEEF; stall high 2 cycles, low in DONE.
- SB addr 0x13, wd 0x000000A5 → `mem_be`=1000, `mem_wd`=0xA5A5A5A5, `mem_we`=1.
- RAM word 0x80F0_7F01 at 0x20:
  - LB 0x23 → `core_rd`=0xFFFFFF80;
  - LBU 0x23 → 0x00000080;
  - LH 0x20 → 0x00007F01;
  - LHU 0x22 → 0x000080F0.
- LW addr 0x22 → `misalign_err` pulse, `core_stall`=0, `mem_req` never asserted; same for LH 0x21 and load size 011.
- LW with `mem_ready` low 3 cycles → stall held 5 cycles total, `mem_*` stable throughout, correct `core_rd` in DONE.
- `rst` asserted mid-BUSY → next cycle IDLE, `mem_req`=0, `core_rd`=0; subsequent SW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the data load/store unit: access-size codes,
// FSM state encoding and small decode helpers.
package lsu_pkg;

    // Access sizes, matching the core's funct3 field.
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // A request is legal when its size code exists for the direction and the
    // address is naturally aligned for that size.
    function automatic logic req_legal(input logic we, input logic [2:0] size,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            LDST_B:  ok = 1'b1;
            LDST_H:  ok = ~addr_lo[0];
            LDST_W:  ok = (addr_lo == 2'b00);
            LDST_BU: ok = ~we;
            LDST_HU: ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables; bit 2 of size (unsigned flag) does not affect lanes.
    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the RAM only needs byte enables.
    function automatic logic [31:0] store_rep(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        case (size[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane selection followed by sign or zero extension.
    always_comb begin
        lane_b = 8'h00;
        lane_h = addr_lo[1] ? rd[31:16] : rd[15:0];
        data   = rd;
        case (addr_lo)
            2'b00: lane_b = rd[7:0];
            2'b01: lane_b = rd[15:8];
            2'b10: lane_b = rd[23:16];
            2'b11: lane_b = rd[31:24];
            default: lane_b = 8'h00;
        endcase
        case (size)
            LDST_B:  data = {{24{lane_b[7]}}, lane_b};
            LDST_BU: data = {24'h000000, lane_b};
            LDST_H:  data = {{16{lane_h[15]}}, lane_h};
            LDST_HU: data = {16'h0000, lane_h};
            default: data = rd;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit: turns core byte/half/word requests into word-aligned RAM
// accesses and stalls the core until the access has completed.
//
// state | meaning
// IDLE  | waiting for a core request; illegal requests are flagged here
// BUSY  | RAM access in flight from the latched request
// DONE  | access finished, core released for one cycle, core_rd valid
module data_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_size,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wd,
    output logic [DATA_W-1:0] core_rd,
    output logic              core_stall,
    output logic              misalign_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic              mem_ready
);

    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] load_data;
    logic              legal;
    logic              in_idle;
    logic              in_busy;

    assign legal   = req_legal(core_we, core_size, core_addr[1:0]);
    assign in_idle = (state == IDLE);
    assign in_busy = (state == BUSY);

    // Stall covers the accepting IDLE cycle and every BUSY cycle; DONE releases.
    assign core_stall   = (in_idle & core_req & legal) | in_busy;
    assign misalign_err = in_idle & core_req & ~legal;

    // RAM side depends only on state and the latched request.
    assign mem_req  = in_busy;
    assign mem_we   = in_busy & we_q;
    assign mem_be   = in_busy ? lane_be(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wd   = store_rep(size_q, wd_q);

    lsu_load_align u_align (
        .rd      (mem_rd),
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .data    (load_data)
    );

    // Sequencing FSM and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            size_q <= 3'b000;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req && legal) begin
                        we_q   <= core_we;
                        size_q <= core_size;
                        addr_q <= core_addr;
                        wd_q   <= core_wd;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load result captured on the completing BUSY cycle; stores leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rd <= '0;
        end else if (in_busy && mem_ready && !we_q) begin
            core_rd <= load_data;
        end
    end

endmodule

// File: tb/tb_data_lsu.sv
// Directed bench for data_lsu: vector table plus reset/wait-state sequences.
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        misalign_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;
    logic        ram_init;

    logic [31:0] ram [0:255];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_size    (core_size),
        .core_addr    (core_addr),
        .core_wd      (core_wd),
        .core_rd      (core_rd),
        .core_stall   (core_stall),
        .misalign_err (misalign_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .mem_ready    (mem_ready)
    );

    // RAM model: combinational read, byte-enabled clocked write.
    assign mem_rd = (mem_addr[31:10] == 22'd0 && mem_addr[1:0] == 2'b00) ? ram[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[8] <= 32'h80F0_7F01;
        end else if (mem_req && mem_we && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One core transaction; records what the RAM side and core side saw.
    task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_n,
                          output logic err, output int stall_n, output int busy_n,
                          output logic [3:0] be, output logic [31:0] mwd, output logic [31:0] maddr,
                          output logic mwe, output logic [31:0] rd, output logic stable,
                          output logic timeout);
        err = 1'b0; stall_n = 0; busy_n = 0; be = 4'h0; mwd = 32'h0; maddr = 32'h0;
        mwe = 1'b0; rd = 32'h0; stable = 1'b1; timeout = 1'b1;
        @(posedge clk); #1;
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (misalign_err) err = 1'b1;
            if (mem_req) begin
                if (busy_n == 0) begin
                    be = mem_be; mwd = mem_wd; maddr = mem_addr; mwe = mem_we;
                end else if (mem_be !== be || mem_wd !== mwd || mem_addr !== maddr || mem_we !== mwe) begin
                    stable = 1'b0;
                end
                busy_n++;
                mem_ready = (busy_n > wait_n);
            end
            if (core_stall) begin
                stall_n++;
            end else begin
                rd = core_rd;
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        core_req = 1'b0;
        mem_ready = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        int          wait_n;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwd;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs [17];

    logic        r_err, r_mwe, r_stable, r_to;
    int          r_stall, r_busy;
    logic [3:0]  r_be;
    logic [31:0] r_mwd, r_maddr, r_rd;

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h10, 32'h0,        2};
        vecs[1]  = '{1'b1, 3'b000, 32'h13, 32'h000000A5, 0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h10, 32'h0,        2};
        vecs[2]  = '{1'b0, 3'b010, 32'h10, 32'h0,        3, 1'b0, 4'hF, 32'h0,        32'h10, 32'hA5ADBEEF, 5};
        vecs[3]  = '{1'b0, 3'b000, 32'h23, 32'h0,        0, 1'b0, 4'h8, 32'h0,        32'h20, 32'hFFFFFF80, 2};
        vecs[4]  = '{1'b0, 3'b100, 32'h23, 32'h0,        0, 1'b0, 4'h8, 32'h0,        32'h20, 32'h00000080, 2};
        vecs[5]  = '{1'b0, 3'b001, 32'h20, 32'h0,        0, 1'b0, 4'h3, 32'h0,        32'h20, 32'h00007F01, 2};
        vecs[6]  = '{1'b0, 3'b101, 32'h22, 32'h0,        0, 1'b0, 4'hC, 32'h0,        32'h20, 32'h000080F0, 2};
        vecs[7]  = '{1'b1, 3'b001, 32'h22, 32'h12345678, 0, 1'b0, 4'hC, 32'h56785678, 32'h20, 32'h000080F0, 2};
        vecs[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,        0, 1'b0, 4'hF, 32'h0,        32'h20, 32'h56787F01, 2};
        vecs[9]  = '{1'b0, 3'b000, 32'h21, 32'h0,        0, 1'b0, 4'h2, 32'h0,        32'h20, 32'h0000007F, 2};
        vecs[10] = '{1'b0, 3'b001, 32'h22, 32'h0,        0, 1'b0, 4'hC, 32'h0,        32'h20, 32'h00005678, 2};
        vecs[11] = '{1'b0, 3'b010, 32'h22, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0,  32'h00005678, 0};
        vecs[12] = '{1'b0, 3'b001, 32'h21, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0,  32'h00005678, 0};
        vecs[13] = '{1'b0, 3'b011, 32'h20, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0,  32'h00005678, 0};
        vecs[14] = '{1'b1, 3'b100, 32'h20, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0,  32'h00005678, 0};
        vecs[15] = '{1'b1, 3'b010, 32'h11, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0,  32'h00005678, 0};
        vecs[16] = '{1'b0, 3'b000, 32'h12, 32'h0,        0, 1'b0, 4'h4, 32'h0,        32'h10, 32'hFFFFFFAD, 2};

        rst = 1'b1; ram_init = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_size = 3'b000; core_addr = 32'h0; core_wd = 32'h0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset core_rd", core_rd, 32'h0);
        chk("reset mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset mem_we", {31'h0, mem_we}, 32'h0);
        chk("reset mem_be", {28'h0, mem_be}, 32'h0);
        chk("reset stall", {31'h0, core_stall}, 32'h0);
        chk("reset misalign", {31'h0, misalign_err}, 32'h0);
        rst = 1'b0; ram_init = 1'b0;

        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].wait_n,
                   r_err, r_stall, r_busy, r_be, r_mwd, r_maddr, r_mwe, r_rd, r_stable, r_to);
            chk($sformatf("v%0d timeout", i), {31'h0, r_to}, 32'h0);
            chk($sformatf("v%0d misalign", i), {31'h0, r_err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d stall_cycles", i), r_stall, vecs[i].exp_stall);
            chk($sformatf("v%0d busy_cycles", i), r_busy, vecs[i].exp_err ? 0 : vecs[i].wait_n + 1);
            chk($sformatf("v%0d mem_be", i), {28'h0, r_be}, {28'h0, vecs[i].exp_be});
            chk($sformatf("v%0d mem_wd", i), r_mwd, vecs[i].exp_mwd);
            chk($sformatf("v%0d mem_addr", i), r_maddr, vecs[i].exp_maddr);
            chk($sformatf("v%0d mem_we", i), {31'h0, r_mwe}, {31'h0, vecs[i].we & ~vecs[i].exp_err});
            chk($sformatf("v%0d core_rd", i), r_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d mem_stable", i), {31'h0, r_stable}, 32'h1);
        end

        // Reset while a store is held in BUSY by a not-ready RAM.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b1; core_size = 3'b010; core_addr = 32'h30; core_wd = 32'h11111111;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rstseq idle stall", {31'h0, core_stall}, 32'h1);
        @(negedge clk);
        chk("rstseq busy mem_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1; core_req = 1'b0;
        #1;
        chk("rstseq mem_req", {31'h0, mem_req}, 32'h0);
        chk("rstseq core_rd", core_rd, 32'h0);
        chk("rstseq mem_be", {28'h0, mem_be}, 32'h0);
        chk("rstseq stall", {31'h0, core_stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("rstseq no write", ram[12], 32'h0);
        chk("rstseq idle mem_req", {31'h0, mem_req}, 32'h0);

        do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 0,
               r_err, r_stall, r_busy, r_be, r_mwd, r_maddr, r_mwe, r_rd, r_stable, r_to);
        chk("post-rst sw stall", r_stall, 2);
        chk("post-rst sw be", {28'h0, r_be}, 32'hF);
        chk("post-rst sw ram", ram[12], 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 0,
               r_err, r_stall, r_busy, r_be, r_mwd, r_maddr, r_mwe, r_rd, r_stable, r_to);
        chk("post-rst lw rd", r_rd, 32'hCAFEF00D);
        chk("post-rst lw timeout", {31'h0, r_to}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
